adc_avg_capture: RTL and testbench
==================================

# adc_avg_capture

Triggered two-channel ADC averager feeding the ADC_A/ADC_B inputs of the GPIO bridge in the SPGD design. On a start pulse from the processor side it:
- waits a programmable settle time for the DAC perturbation to propagate;
- accumulates 2^LOG2_N samples per channel;
- presents the truncated means as stable 12-bit words with a sticky done flag, so software reads noise-reduced metric values rather than raw samples.

## Interface
- ADC_WIDTH, 12: sample and output width, unsigned.
- LOG2_N, 4: log2 of samples averaged; legal 0..10.
- SETTLE_WIDTH, 16: width of the settle-cycle count.

- clk  in  1  ADC sample clock, single clock domain.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle trigger; honoured only in IDLE or DONE.
- settle_cycles  in  SETTLE_WIDTH  cycles to wait before accumulating; latched on accepted start.
- ADC_A_IN  in  ADC_WIDTH  raw channel A sample, new value every cycle.
- ADC_B_IN  in  ADC_WIDTH  raw channel B sample.
- ADC_A  out  ADC_WIDTH  averaged channel A; reset 0.
- ADC_B  out  ADC_WIDTH  averaged channel B; reset 0.
- busy  out  1  high in SETTLE and ACCUM; reset 0.
- done  out  1  high in DONE, sticky until next accepted start; reset 0.

## Operation
- **Input registers:**
  - ADC_A_IN/ADC_B_IN are registered every cycle into a_q/b_q; reset 0.
  - All arithmetic uses a_q/b_q.
- **FSM states:** IDLE, SETTLE, ACCUM, DONE; reset state IDLE.
- **IDLE/DONE + start:**
  - Latch settle_cycles into the settle counter.
  - Clear both accumulators and the sample counter.
  - Clear done.
  - Go to SETTLE if settle_cycles ≠ 0, else ACCUM.
- **SETTLE:** decrement the counter each cycle; move to ACCUM in the cycle after it reaches 1, so exactly settle_cycles cycles are spent in SETTLE.
- **ACCUM:**
  - Each cycle: acc_a += a_q, acc_b += b_q, sample count += 1.
  - After 2^LOG2_N cycles go to DONE.
- **Entering DONE:**
  - ADC_A = acc_a[ADC_WIDTH+LOG2_N-1:LOG2_N]; ADC_B likewise.
  - Division is truncation; no rounding.
  - done = 1.
- **Accumulator width:** ADC_WIDTH+LOG2_N bits, which is overflow-free by construction.
- **ADC_A/ADC_B hold:** they change only when entering DONE and keep the previous result through a new SETTLE/ACCUM.
- **start in SETTLE/ACCUM:** ignored; no restart, no latch.
- **start coincident with RST:** RST wins.
- **RST in any state:**
  - Next cycle: IDLE.
  - Outputs 0, busy 0, done 0.
  - Accumulators and counters cleared.
- **LOG2_N = 0:** single-sample capture, 1 ACCUM cycle.

## Timing
Let S = settle_cycles and N = 2^LOG2_N, with start accepted at cycle edge t.
- t+1 .. t+S: SETTLE (absent if S = 0).
- t+S+1 .. t+S+N: ACCUM.
- Samples summed: ADC_A_IN/ADC_B_IN values presented at cycles t+S .. t+S+N-1.
- t+S+N+1: DONE. done = 1 and new ADC_A/ADC_B valid on the same edge.
- Total start-to-done latency: S+N+1 cycles.
- busy: high from t+1 through t+S+N, low in the DONE cycle.
- Back-to-back: start asserted in the first DONE cycle is accepted; done drops on the next edge.

## Structure
- State encodings (2-bit) and the LOG2_N legal-range limit go in the shared SPGD defines include, alongside the other FSM encodings.
- ADC_WIDTH default also comes from that include.
- Natural sub-module: adc_acc_chan.
  - Input register, accumulator, truncating output register for one channel.
  - Controlled by clear/enable/load strobes.
  - Instantiated twice.
- FSM and counters stay in the top module.

## Test plan
- **Constant mean (LOG2_N=2, S=3):** ADC_A_IN=100, ADC_B_IN=4000, pulse start.
  - done rises exactly 8 cycles after start; ADC_A=100, ADC_B=4000; busy high for 7 cycles.
- **Ramp and truncation (LOG2_N=2, S=0):** ADC_A_IN = 1,2,3,5 in the sampled window (start cycle onward).
  - ADC_A=2 (11>>2); done 5 cycles after start.
- **Full scale:** ADC_A_IN=ADC_B_IN=4095, LOG2_N=4.
  - Outputs 4095; no wrap.
- **start during busy:** second start mid-ACCUM.
  - Ignored; done timing and result identical to a single-start run.
- **Reset mid-ACCUM:** RST for 1 cycle.
  - Next cycle: IDLE, busy=0, done=0, ADC_A=ADC_B=0.
  - A following start produces a correct fresh average.
- **Hold and re-trigger:** after a first result of 100, restart with input 200.
  - ADC_A stays 100 through SETTLE/ACCUM and switches to 200 exactly when done re-asserts.

Source files
------------

// File: rtl/adc_avg_capture_pkg.sv
// adc_avg_capture_pkg
// Shared definitions for the triggered two-channel ADC averager:
//   - state_e       : 2-bit FSM encoding (IDLE/SETTLE/ACCUM/DONE)
//   - ADC_WIDTH_DEF : default sample/output width
//   - LOG2_N_MAX    : largest legal log2 of the averaging length
package adc_avg_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int ADC_WIDTH_DEF = 12;
    localparam int LOG2_N_MAX    = 10;

endpackage

// File: rtl/adc_avg_capture_chan.sv
// adc_acc_chan
// One averaging channel: input register, accumulator and truncating output
// register, driven by clear/enable/load strobes from the controlling FSM.
// Ports:
//   clk       : clock
//   rst_i     : synchronous active-high reset (clears everything)
//   clear_i   : zero the accumulator
//   en_i      : add the registered sample into the accumulator
//   load_i    : capture the truncated mean of (accumulator + current sample)
//   sample_i  : raw sample, registered every cycle
//   avg_o     : last captured mean
module adc_acc_chan #(
    parameter int ADC_WIDTH = 12,
    parameter int LOG2_N    = 4
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [ADC_WIDTH-1:0] sample_i,
    output logic [ADC_WIDTH-1:0] avg_o
);
    // Wide enough for 2^LOG2_N full-scale samples, so no overflow is possible.
    localparam int ACC_W = ADC_WIDTH + LOG2_N;

    logic [ADC_WIDTH-1:0] sample_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_d;
    logic [ADC_WIDTH-1:0] avg_q;

    assign acc_d = acc_q + ACC_W'(sample_q);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sample_q <= '0;
            acc_q    <= '0;
            avg_q    <= '0;
        end else begin
            sample_q <= sample_i;
            if (clear_i) begin
                acc_q <= '0;
            end else if (en_i) begin
                acc_q <= acc_d;
            end
            // The load happens on the last accumulate edge, so the mean is
            // taken from the sum that includes the final sample.
            if (load_i) begin
                avg_q <= acc_d[ACC_W-1:LOG2_N];
            end
        end
    end

    assign avg_o = avg_q;

endmodule

// File: rtl/adc_avg_capture.sv
// adc_avg_capture
// Triggered two-channel ADC averager. A start pulse (accepted in IDLE or DONE)
// waits settle_cycles, sums 2^LOG2_N samples per channel, then presents the
// truncated means with a sticky done flag.
// Ports:
//   clk, RST       : clock, synchronous active-high reset
//   start          : one-cycle trigger
//   settle_cycles  : settle wait, latched on an accepted start
//   ADC_A_IN/B_IN  : raw samples
//   ADC_A/ADC_B    : averaged results, held until the next completion
//   busy           : high in SETTLE and ACCUM
//   done           : high in DONE
module adc_avg_capture
    import adc_avg_capture_pkg::*;
#(
    parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
    parameter int LOG2_N       = 4,
    parameter int SETTLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    start,
    input  logic [SETTLE_WIDTH-1:0] settle_cycles,
    input  logic [ADC_WIDTH-1:0]    ADC_A_IN,
    input  logic [ADC_WIDTH-1:0]    ADC_B_IN,
    output logic [ADC_WIDTH-1:0]    ADC_A,
    output logic [ADC_WIDTH-1:0]    ADC_B,
    output logic                    busy,
    output logic                    done
);
    localparam int                CNT_W    = LOG2_N + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    state_e                  state_q;
    logic [SETTLE_WIDTH-1:0] settle_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q;
    logic                    done_q;

    logic accept;
    logic acc_en;
    logic acc_load;

    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign acc_en   = (state_q == ST_ACCUM);
    assign acc_load = acc_en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        settle_q <= settle_cycles;
                        cnt_q    <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= (settle_cycles != '0) ? ST_SETTLE : ST_ACCUM;
                    end
                end
                ST_SETTLE: begin
                    settle_q <= settle_q - SETTLE_WIDTH'(1);
                    if (settle_q == SETTLE_WIDTH'(1)) begin
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Channel 0 is A, channel 1 is B.
    logic [1:0][ADC_WIDTH-1:0] samp_in;
    logic [1:0][ADC_WIDTH-1:0] avg_out;

    assign samp_in[0] = ADC_A_IN;
    assign samp_in[1] = ADC_B_IN;

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        adc_acc_chan #(
            .ADC_WIDTH (ADC_WIDTH),
            .LOG2_N    (LOG2_N)
        ) u_chan (
            .clk      (clk),
            .rst_i    (RST),
            .clear_i  (accept),
            .en_i     (acc_en),
            .load_i   (acc_load),
            .sample_i (samp_in[gi]),
            .avg_o    (avg_out[gi])
        );
    end

    assign ADC_A = avg_out[0];
    assign ADC_B = avg_out[1];
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_adc_avg_capture.sv
module tb_adc_avg_capture;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] settle;
    logic [11:0] a_in;
    logic [11:0] b_in;

    logic [11:0] adc_a2, adc_b2, adc_a4, adc_b4;
    logic        busy2, done2, busy4, done4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adc_avg_capture #(.ADC_WIDTH(12), .LOG2_N(2), .SETTLE_WIDTH(16)) u_dut2 (
        .clk(clk), .RST(RST), .start(start), .settle_cycles(settle),
        .ADC_A_IN(a_in), .ADC_B_IN(b_in),
        .ADC_A(adc_a2), .ADC_B(adc_b2), .busy(busy2), .done(done2)
    );

    adc_avg_capture #(.ADC_WIDTH(12), .LOG2_N(4), .SETTLE_WIDTH(16)) u_dut4 (
        .clk(clk), .RST(RST), .start(start), .settle_cycles(settle),
        .ADC_A_IN(a_in), .ADC_B_IN(b_in),
        .ADC_A(adc_a4), .ADC_B(adc_b4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until done of the selected DUT rises (bounded).
    task automatic wait_done(input bit four, output int lat);
        lat = 0;
        while (!(four ? done4 : done2) && lat < 100) begin
            tick(1);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;

        RST = 1'b1; start = 1'b0; settle = '0; a_in = '0; b_in = '0;
        tick(2);
        check("reset_adc_a", 32'(adc_a2), 0);
        check("reset_adc_b", 32'(adc_b2), 0);
        check("reset_busy",  32'(busy2), 0);
        check("reset_done",  32'(done2), 0);
        check("reset_l4_done", 32'(done4), 0);
        RST = 1'b0;
        tick(1);
        $display("txn reset: ADC_A=%0d ADC_B=%0d busy=%0d done=%0d", adc_a2, adc_b2, busy2, done2);

        // Constant mean, S=3, N=4
        a_in = 12'd100; b_in = 12'd4000; settle = 16'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        lat = 0; bc = 0;
        while (!done2 && lat < 100) begin
            if (busy2) bc++;
            tick(1);
            lat++;
        end
        check("const_latency", 32'(lat), 7);
        check("const_busy_cycles", 32'(bc), 7);
        check("const_adc_a", 32'(adc_a2), 100);
        check("const_adc_b", 32'(adc_b2), 4000);
        check("const_busy_in_done", 32'(busy2), 0);
        $display("txn const: lat=%0d busy_cycles=%0d ADC_A=%0d ADC_B=%0d", lat, bc, adc_a2, adc_b2);

        // Ramp and truncation, S=0; start issued in the first DONE cycle
        settle = 16'd0; a_in = 12'd1; b_in = 12'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("b2b_done_drop", 32'(done2), 0);
        check("b2b_busy", 32'(busy2), 1);
        check("ramp_hold_a", 32'(adc_a2), 100);
        a_in = 12'd2; tick(1);
        a_in = 12'd3; tick(1);
        a_in = 12'd5; tick(1);
        check("ramp_not_yet_done", 32'(done2), 0);
        a_in = 12'd99; tick(1);
        check("ramp_done", 32'(done2), 1);
        check("ramp_adc_a", 32'(adc_a2), 2);
        check("ramp_adc_b", 32'(adc_b2), 0);
        $display("txn ramp: ADC_A=%0d ADC_B=%0d done=%0d", adc_a2, adc_b2, done2);

        // Full scale on the 16-sample instance
        tick(30);
        a_in = 12'd4095; b_in = 12'd4095; settle = 16'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(1'b1, lat);
        check("full_l4_latency", 32'(lat), 16);
        check("full_l4_adc_a", 32'(adc_a4), 4095);
        check("full_l4_adc_b", 32'(adc_b4), 4095);
        check("full_l2_adc_a", 32'(adc_a2), 4095);
        $display("txn full: L4 ADC_A=%0d ADC_B=%0d lat=%0d", adc_a4, adc_b4, lat);

        // Start during ACCUM must be ignored
        a_in = 12'd40; b_in = 12'd7; settle = 16'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        start = 1'b1; settle = 16'd0;
        tick(1);
        start = 1'b0;
        check("busy_restart_busy", 32'(busy2), 1);
        wait_done(1'b0, lat);
        check("busy_restart_latency", 32'(lat + 4), 6);
        check("busy_restart_adc_a", 32'(adc_a2), 40);
        check("busy_restart_adc_b", 32'(adc_b2), 7);
        $display("txn restart_ignored: lat=%0d ADC_A=%0d ADC_B=%0d", lat + 4, adc_a2, adc_b2);

        // Reset mid-ACCUM, with a coincident start that must lose
        a_in = 12'd500; b_in = 12'd500; settle = 16'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        RST = 1'b1; start = 1'b1;
        tick(1);
        RST = 1'b0; start = 1'b0;
        check("rst_busy", 32'(busy2), 0);
        check("rst_done", 32'(done2), 0);
        check("rst_adc_a", 32'(adc_a2), 0);
        check("rst_adc_b", 32'(adc_b2), 0);
        check("rst_l4_adc_a", 32'(adc_a4), 0);
        tick(1);
        check("rst_start_ignored", 32'(busy2), 0);
        a_in = 12'd300; b_in = 12'd1234; settle = 16'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(1'b0, lat);
        check("post_rst_latency", 32'(lat), 5);
        check("post_rst_adc_a", 32'(adc_a2), 300);
        check("post_rst_adc_b", 32'(adc_b2), 1234);
        $display("txn reset_recover: lat=%0d ADC_A=%0d ADC_B=%0d", lat, adc_a2, adc_b2);

        // Hold and re-trigger
        a_in = 12'd100; b_in = 12'd100; settle = 16'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(1'b0, lat);
        check("hold_first_adc_a", 32'(adc_a2), 100);
        a_in = 12'd200; start = 1'b1;
        tick(1);
        start = 1'b0;
        lat = 0;
        while (!done2 && lat < 100) begin
            check("hold_during_busy", 32'(adc_a2), 100);
            tick(1);
            lat++;
        end
        check("hold_retrig_latency", 32'(lat), 6);
        check("hold_retrig_adc_a", 32'(adc_a2), 200);
        $display("txn hold_retrigger: lat=%0d ADC_A=%0d", lat, adc_a2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
